if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

  localparam int XLEN        = 32;
  localparam int FETCH_DEPTH = 2;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_BUBBLE     = 32'h0000_0000;

  // One buffered fetch result: the address it came from and the word returned.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with flush. Used for the in-flight address queue
// and for the {pc, instr} response buffer in the fetch unit.
module fetch_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

  // A flush discards everything, so it suppresses both push and pop.
  // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  assign o_data = r_mem[r_rd_ptr];

  // Storage write.
  // NOTE: the storage array has no reset; stale contents are never observed
  // because every consumer qualifies o_data with o_empty, and leaving it
  // unreset lets it map onto plain registers or LUT RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy update.
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory under a
// two-credit budget, buffers returned words, and presents the oldest one to
// the decode pipeline register. A decode redirect flushes buffered words and
// turns every still-outstanding response into a discard.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = FETCH_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_F,
  input  logic            PCSrcD,
  input  logic [XLEN-1:0] PCBranchD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            valid_F,
  output logic [XLEN-1:0] PC_F,
  output logic [XLEN-1:0] Instr_F,
  output logic [XLEN-1:0] PC_Plus4_F
);

  localparam logic [2:0] L_DEPTH = 3'(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [1:0]      r_inflight;
  logic [1:0]      r_drop;

  logic            w_aq_full;
  logic            w_aq_empty;
  logic [XLEN-1:0] w_aq_addr;
  logic            w_buf_full;
  logic            w_buf_empty;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic [1:0]      w_buf_cnt;
  logic [2:0]      w_used;
  logic            w_issue;
  logic            w_resp;
  logic            w_keep;
  logic            w_pop;

  // Credits: in-flight requests plus buffered words may not exceed DEPTH.
  // rst_n gates the request so nothing is asked for while in reset.
  assign w_buf_cnt = w_buf_full ? 2'd2 : (w_buf_empty ? 2'd0 : 2'd1);
  assign w_used    = {1'b0, r_inflight} + {1'b0, w_buf_cnt};
  assign imem_req  = rst_n && (w_used < L_DEPTH) && !PCSrcD;
  assign imem_addr = r_pc;

  assign w_issue = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp  = imem_rvalid && (r_inflight != 2'd0);
  // Responses owed to a redirected path, or arriving with a redirect, are dropped.
  assign w_keep  = w_resp && (r_drop == 2'd0) && !PCSrcD;
  assign w_pop   = !w_buf_empty && !stall_F && !PCSrcD;

  assign w_push_entry = '{pc: w_aq_addr, instr: imem_rdata};

  // Addresses of outstanding requests; drains with responses, never flushed.
  fetch_fifo #(.WIDTH(XLEN)) u_addr_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (1'b0),
    .i_push  (w_issue),
    .i_data  (r_pc),
    .i_pop   (w_resp),
    .o_data  (w_aq_addr),
    .o_full  (w_aq_full),
    .o_empty (w_aq_empty)
  );

  // Returned {pc, instr} words waiting for the pipeline register.
  fetch_fifo #(.WIDTH(ENTRY_W)) u_resp_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (PCSrcD),
    .i_push  (w_keep),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty)
  );

  // Fetch PC: redirect wins, otherwise advance one word per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (PCSrcD) begin
      r_pc <= PCBranchD;
    end else if (w_issue) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Outstanding-request and pending-discard counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 2'd0;
      r_drop     <= 2'd0;
    end else begin
      r_inflight <= r_inflight + 2'(w_issue) - 2'(w_resp);
      if (PCSrcD) begin
        r_drop <= r_inflight - 2'(w_resp);
      end else if (w_resp && (r_drop != 2'd0)) begin
        r_drop <= r_drop - 2'd1;
      end
    end
  end

  // Head-of-buffer presentation; an empty buffer shows a bubble at PC 0.
  // NOTE: every output gets a default first so no path through the block
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_F    = 1'b0;
    PC_F       = '0;
    Instr_F    = INSTR_BUBBLE;
    if (!w_buf_empty) begin
      valid_F  = 1'b1;
      PC_F     = w_head.pc;
      Instr_F  = w_head.instr;
    end
    PC_Plus4_F = PC_F + 32'd4;
  end

  // Memory must not return data that was never requested.
  a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (r_inflight == 2'd0)));

  // The address queue holds exactly one entry per outstanding request.
  a_addr_q_tracks : assert property (@(posedge clk) disable iff (!rst_n)
    (w_aq_empty == (r_inflight == 2'd0)) && (w_aq_full == (r_inflight == 2'd2)));

  // The credit rule guarantees the response buffer never overflows.
  a_buf_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_keep && w_buf_full && !w_pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: an in-order memory model with
// configurable latency, a queue-based reference model of the fetch stage,
// and directed scenarios with hand-computed expectations.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'h1357_0000;

  logic        clk;
  logic        rst_n;
  logic        stall_F;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_F;
  logic [31:0] PC_F;
  logic [31:0] Instr_F;
  logic [31:0] PC_Plus4_F;

  if_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_F     (stall_F),
    .PCSrcD      (PCSrcD),
    .PCBranchD   (PCBranchD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .valid_F     (valid_F),
    .PC_F        (PC_F),
    .Instr_F     (Instr_F),
    .PC_Plus4_F  (PC_Plus4_F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory: granted requests waiting to return, in order.
  typedef struct { logic [31:0] addr; int ready; } mreq_t;
  mreq_t mem_q[$];
  int    lat = 1;
  int    cyc = 0;

  // Reference model: outstanding fetches (each tagged keep/discard) and
  // buffered words, in program order.
  typedef struct { logic [31:0] addr; bit drop; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  out_t        m_out[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc;

  // Values observed in the most recent step.
  logic        obs_req, obs_valid, obs_rvalid;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs applied.
  task automatic model_update(bit exp_req);
    bit   do_pop;
    out_t r;
    do_pop = (m_buf.size() > 0) && !stall_F && !PCSrcD;
    if (imem_rvalid && m_out.size() > 0) begin
      r = m_out.pop_front();
      if (!PCSrcD && !r.drop) m_buf.push_back('{r.addr, imem_rdata});
    end
    if (PCSrcD) begin
      foreach (m_out[i]) m_out[i].drop = 1'b1;
      m_buf.delete();
      m_pc = PCBranchD;
    end else begin
      if (do_pop) void'(m_buf.pop_front());
      if (exp_req && imem_gnt) begin
        m_out.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle: entered and left at a falling edge with the caller's
  // inputs already applied. Drives memory, compares all outputs, clocks.
  task automatic step();
    bit          exp_req, exp_valid;
    logic [31:0] exp_pc, exp_instr;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hBAD0_BAD0;
    end
    #1;
    exp_req   = ((m_out.size() + m_buf.size()) < 2) && !PCSrcD;
    exp_valid = m_buf.size() > 0;
    exp_pc    = exp_valid ? m_buf[0].pc    : 32'h0;
    exp_instr = exp_valid ? m_buf[0].instr : 32'h0;
    check("req",   imem_req,   exp_req);
    check("addr",  imem_addr,  m_pc);
    check("valid", valid_F,    exp_valid);
    check("pc",    PC_F,       exp_pc);
    check("instr", Instr_F,    exp_instr);
    check("pc4",   PC_Plus4_F, exp_pc + 32'd4);
    obs_req    = imem_req;
    obs_addr   = imem_addr;
    obs_valid  = valid_F;
    obs_pc     = PC_F;
    obs_instr  = Instr_F;
    obs_rvalid = imem_rvalid;
    @(posedge clk);
    if (obs_rvalid) void'(mem_q.pop_front());
    if (obs_req && imem_gnt) mem_q.push_back('{obs_addr, cyc + lat});
    model_update(exp_req);
    cyc++;
    @(negedge clk);
  endtask

  // Reset from a falling edge; outputs must go idle immediately.
  task automatic do_reset();
    rst_n       = 1'b0;
    PCSrcD      = 1'b0;
    imem_rvalid = 1'b0;
    mem_q.delete();
    m_out.delete();
    m_buf.delete();
    m_pc = RESET_PC;
    #1;
    check("rst_req",   imem_req,   32'd0);
    check("rst_valid", valid_F,    32'd0);
    check("rst_pc",    PC_F,       32'd0);
    check("rst_instr", Instr_F,    32'd0);
    check("rst_pc4",   PC_Plus4_F, 32'd4);
    check("rst_addr",  imem_addr,  RESET_PC);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] pcs[$];
    logic [29:0] stall_tab;
    logic [29:0] gnt_tab;
    bit          seen;

    rst_n = 1'b0; stall_F = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);

    // Streaming fetch with one-cycle memory.
    lat = 1; stall_F = 0; imem_gnt = 1;
    do_reset();
    step(); check("a0_req", obs_req, 1); check("a0_addr", obs_addr, 32'h0);
    step(); check("a1_addr", obs_addr, 32'h4); check("a1_valid", obs_valid, 0);
    step(); check("a2_valid", obs_valid, 1); check("a2_pc", obs_pc, 32'h0);
    check("a2_instr", obs_instr, 32'h1357_0000); check("a2_req", obs_req, 0);
    step(); check("a3_addr", obs_addr, 32'h8); check("a3_pc", obs_pc, 32'h4);
    for (int i = 0; i < 6; i++) step();

    // Stall with a full buffer.
    stall_F = 1;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("b_req", obs_req, 0);
      check("b_pc", obs_pc, 32'h0);
    end
    stall_F = 0;
    pcs.delete();
    for (int i = 0; i < 10 && pcs.size() < 3; i++) begin
      step();
      if (obs_valid) pcs.push_back(obs_pc);
    end
    check("b_npops", pcs.size(), 3);
    if (pcs.size() == 3) begin
      check("b_pop0", pcs[0], 32'h0);
      check("b_pop1", pcs[1], 32'h4);
      check("b_pop2", pcs[2], 32'h8);
    end

    // Redirect with two slow responses outstanding.
    lat = 3;
    do_reset();
    step(); step(); check("c_req_full", imem_req, 0);
    PCSrcD = 1; PCBranchD = 32'h100;
    step();
    PCSrcD = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (obs_valid) begin
        seen = 1;
        check("c_first_pc", obs_pc, 32'h100);
        check("c_first_instr", obs_instr, 32'h1357_0100);
      end
    end
    check("c_seen_valid", seen, 1);

    // Redirect in the same cycle as a response and a pop.
    lat = 1;
    do_reset();
    step(); step();
    PCSrcD = 1; PCBranchD = 32'h200;
    step();
    check("d_coincide", {obs_valid, obs_rvalid}, 2'b11);
    PCSrcD = 0;
    step();
    check("d_valid", obs_valid, 0);
    check("d_req", obs_req, 1);
    check("d_addr", obs_addr, 32'h200);
    for (int i = 0; i < 4; i++) step();

    // Grant withheld.
    imem_gnt = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check("e_req", obs_req, 1);
      check("e_addr", obs_addr, 32'h0);
    end
    imem_gnt = 1;
    step(); check("e_grant_addr", obs_addr, 32'h0);
    step(); check("e_next_addr", obs_addr, 32'h4);

    // Reset with two requests in flight.
    lat = 3;
    do_reset();
    step(); step();
    do_reset();
    step(); check("f_req", obs_req, 1); check("f_addr", obs_addr, RESET_PC);
    for (int i = 0; i < 8; i++) step();

    // Mixed stall/grant pattern with two redirects, one to an unaligned target.
    lat = 2;
    stall_tab = 30'b001100_000111_010010_001100_000110;
    gnt_tab   = 30'b111011_110111_101111_111101_111011;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      stall_F  = stall_tab[i];
      imem_gnt = gnt_tab[i];
      PCSrcD   = (i == 9) || (i == 20);
      PCBranchD = (i == 9) ? 32'h400 : 32'h806;
      step();
    end
    PCSrcD = 0; stall_F = 0; imem_gnt = 1;
    for (int i = 0; i < 8; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
